// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running pixel/line counters decoded into registered
// coordinate, visible-area, sync, frame-boundary and frame-count outputs.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       screen_reset,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       vis_d;
    logic       hsync_d;
    logic       vsync_d;
    logic       pulse_d;

    // Next-count logic: the line counter only moves on the cycle the pixel counter wraps.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Decode from the current counters; the registers below line everything up one cycle later.
    always_comb begin
        vis_d   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_d = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_d = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        pulse_d = (h_cnt == 10'd0) && (v_cnt == V_VIS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt        <= 10'd0;
            v_cnt        <= 10'd0;
            col          <= 10'd0;
            row          <= 10'd0;
            valid        <= 1'b0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            screen_reset <= 1'b0;
            frame_cnt    <= 8'd0;
        end else begin
            h_cnt        <= h_next;
            v_cnt        <= v_next;
            col          <= h_cnt;
            row          <= v_cnt;
            valid        <= vis_d;
            hsync        <= hsync_d;
            vsync        <= vsync_d;
            screen_reset <= pulse_d;
            // Counted on the same edge the pulse is raised, so both read consistently.
            if (pulse_d) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
